// File: rtl/up_state_ctrl.sv
// Top-level state controller: boots a program image from a word stream into main
// memory, then arbitrates memory to the core and sequences pause/resume handshakes.
module up_state_ctrl #(
  parameter int unsigned BOOT_WORDS     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_bootData,
  input  logic        i_bootValid,
  output logic        o_bootReady,
  input  logic [15:0] i_coreMemAddr,
  input  logic [15:0] i_coreMemDataOut,
  input  logic        i_coreMemWr,
  output logic [15:0] o_memAddr,
  output logic [15:0] o_memDataOut,
  output logic        o_memWr,
  output logic        o_smIsBooted,
  output logic        o_smStartPause,
  input  logic        i_smNowPaused,
  input  logic        i_coreHLT,
  input  logic        i_pauseReq,
  input  logic        i_resumeReq,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [15:0] LAST_WORD   = 16'(BOOT_WORDS - 1);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
  localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] idle_q, idle_d;
  logic        booted_q, booted_d;
  logic        pause_q, pause_d;
  logic        boot_ready_s;
  logic        beat_s;

  assign boot_ready_s = (state_q == ST_BOOT) && !i_rst;
  assign beat_s       = boot_ready_s && i_bootValid;

  // Next-state, boot counter and idle-timeout logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    case (state_q)
      ST_BOOT: begin
        if (beat_s) begin
          cnt_d  = cnt_q + 16'd1;
          idle_d = 32'd0;
          if (cnt_q == LAST_WORD) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_BOOT;
          end
        end else if (TIMEOUT_EN && (idle_q >= TIMEOUT_LIM)) begin
          state_d = ST_ERROR;
        end else if (TIMEOUT_EN) begin
          idle_d = idle_q + 32'd1;
        end else begin
          idle_d = idle_q;
        end
      end
      ST_RUN: begin
        if (i_pauseReq || i_coreHLT) begin
          state_d = ST_PAUSING;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSING: begin
        if (i_smNowPaused) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_PAUSING;
        end
      end
      ST_PAUSED: begin
        if (i_resumeReq && !i_pauseReq) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    // Core-facing flags are derived from the next state so they track it registered.
    booted_d = (state_d == ST_RUN) || (state_d == ST_PAUSING) || (state_d == ST_PAUSED);
    pause_d  = (state_d == ST_PAUSING) || (state_d == ST_PAUSED);
  end

  // State and registered core-facing outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_BOOT;
      cnt_q    <= 16'd0;
      idle_q   <= 32'd0;
      booted_q <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      booted_q <= booted_d;
      pause_q  <= pause_d;
    end
  end

  // Memory port mux: boot path until loaded, core path afterwards.
  always_comb begin
    o_memWr      = 1'b0;
    o_memAddr    = {1'b0, cnt_q[14:0]};
    o_memDataOut = i_bootData;
    case (state_q)
      ST_BOOT: begin
        o_memWr      = beat_s;
        o_memAddr    = {1'b0, cnt_q[14:0]};
        o_memDataOut = i_bootData;
      end
      ST_RUN, ST_PAUSING, ST_PAUSED: begin
        o_memWr      = i_coreMemWr;
        o_memAddr    = i_coreMemAddr;
        o_memDataOut = i_coreMemDataOut;
      end
      ST_ERROR: begin
        o_memWr      = 1'b0;
        o_memAddr    = {1'b0, cnt_q[14:0]};
        o_memDataOut = i_bootData;
      end
      default: begin
        o_memWr      = 1'b0;
        o_memAddr    = {1'b0, cnt_q[14:0]};
        o_memDataOut = i_bootData;
      end
    endcase
  end

  assign o_bootReady    = boot_ready_s;
  assign o_smIsBooted   = booted_q;
  assign o_smStartPause = pause_q;
  assign o_state        = state_q;

endmodule

// File: doc/up_state_ctrl.md
# up_state_ctrl

Top-level microprocessor state controller. It sits directly upstream of the core and drives the core's `smIsBooted` and `smStartPause` inputs. After reset it copies a program image from a word-stream boot source into main memory, then hands memory to the core. It sequences pause and resume, both requested externally and caused by the core halting, using a handshake against the core's `smNowPaused` acknowledge.

## Interface
Parameters:
- `BOOT_WORDS`, default 1024: image length in 16-bit words; legal range 1..32768.
- `TIMEOUT_CYCLES`, default 65535: maximum consecutive BOOT cycles without a transfer beat; 0 disables the timeout.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_bootData` in 16: boot source word.
- `i_bootValid` in 1: boot source word valid.
- `o_bootReady` out 1: controller accepting boot words.
- `i_coreMemAddr` in 16: core memory address.
- `i_coreMemDataOut` in 16: core write data.
- `i_coreMemWr` in 1: core write enable.
- `o_memAddr` out 16: to memory.
- `o_memDataOut` out 16: to memory.
- `o_memWr` out 1: to memory.
- `o_smIsBooted` out 1: to core; image loaded.
- `o_smStartPause` out 1: to core; pause request.
- `i_smNowPaused` in 1: from core; pause acknowledge.
- `i_coreHLT` in 1: from core; HLT is executing.
- `i_pauseReq` in 1: external pause request, level-sampled.
- `i_resumeReq` in 1: external resume request, level-sampled.
- `o_state` out 3: current state, for debug/LEDs.

## Operation
- States and `o_state` encodings: BOOT=0, RUN=1, PAUSING=2, PAUSED=3, ERROR=4.
- Reset state is BOOT. On reset the following clear:
  - word counter and idle counter to 0;
  - `o_smIsBooted`=0, `o_smStartPause`=0, `o_state`=0;
  - `o_bootReady`=0 while `i_rst`=1.
- A reset in any state, including mid-boot, restarts the load at address 0.

BOOT:
- `o_bootReady`=1.
- A beat is `i_bootValid & o_bootReady`.
- On a beat, the same cycle drives `o_memWr`=1, `o_memAddr`={1'b0, cnt[14:0]}, `o_memDataOut`=`i_bootData`. `cnt` then increments.
- On a non-beat cycle, `o_memWr`=0.
- A beat with cnt==BOOT_WORDS-1 moves to RUN.
- Idle counter: increments on each non-beat cycle and clears on a beat. When it reaches TIMEOUT_CYCLES, go to ERROR.
- If a beat and expiry occur in the same cycle, the beat wins.

RUN:
- Memory ports pass through the core signals combinationally.
- If `i_pauseReq` | `i_coreHLT`, go to PAUSING. Pause takes priority over a simultaneous `i_resumeReq`.

PAUSING:
- `o_smStartPause`=1.
- Wait for `i_smNowPaused`=1, then go to PAUSED.
- `i_resumeReq` and `i_pauseReq` are ignored.

PAUSED:
- `o_smStartPause` stays 1, because the core's pause flop tracks it.
- If `i_resumeReq` & ~`i_pauseReq`, go to RUN.

ERROR:
- Terminal until reset.
- `o_bootReady`=0, `o_memWr`=0, `o_smIsBooted`=0, `o_smStartPause`=0.

Memory mux:
- BOOT/ERROR: boot path drives memory; `o_memAddr`={1'b0, cnt}, `o_memDataOut`=`i_bootData`.
- RUN/PAUSING/PAUSED: core path drives memory.
- Core writes during BOOT are dropped.

## Timing
- `o_smIsBooted`, `o_smStartPause` and `o_state` are registered.
- `o_bootReady` and the memory outputs are combinational from state, counter and inputs.
- Boot write has 0-cycle latency from the beat. Sustained throughput is 1 word/cycle.
- `o_smIsBooted` rises on the cycle after the final beat and stays 1 through RUN, PAUSING and PAUSED.
- Pause sequence:
  - A request sampled at edge N gives `o_smStartPause`=1 from N+1.
  - The core acknowledges from N+2.
  - PAUSED from N+3.
- Resume: `i_resumeReq` sampled at edge M gives `o_smStartPause`=0 from M+1. The core leaves pause at M+2.
- `i_coreHLT` remains high until the core clears its execute stage under `o_smStartPause`. After resume it is 0, so there is no re-trigger.
- The word counter is 16 bits wide so that BOOT_WORDS=32768 terminates without wrap.
- Only cnt[14:0] reaches the address.

## Test plan
- **Full load:** BOOT_WORDS=4, valid held with 0x1111..0x4444.
  - Expect `o_memWr`=1 at addresses 0,1,2,3 on 4 consecutive cycles.
  - `o_smIsBooted`=1 and `o_state`=1 on the next cycle.
  - Afterwards, the core address 0x0002 appears on `o_memAddr`.
- **Gapped source:** TIMEOUT_CYCLES=8, valid drops for 7 cycles between each beat.
  - Expect no ERROR and contiguous addresses 0..3.
- **Timeout:** TIMEOUT_CYCLES=8, valid never asserted.
  - Expect `o_state`=4 exactly 9 cycles after reset release.
  - `o_bootReady`=0 and `o_memWr`=0 thereafter, even if valid later rises.
- **External pause/resume:** in RUN, pulse `i_pauseReq` for 1 cycle, with a core model that echoes `o_smStartPause` with 1-cycle delay.
  - Expect state 2 then 3, and `o_smStartPause`=1.
  - Then pulse `i_resumeReq`: `o_smStartPause`=0 next cycle, state=1.
- **HLT auto-pause:** assert `i_coreHLT` in RUN until `o_smStartPause`=1.
  - Expect PAUSED.
  - Simultaneous `i_pauseReq` and `i_resumeReq` in PAUSED keeps PAUSED.
- **Reset mid-boot:** after 2 beats, assert `i_rst` for 1 cycle.
  - Expect the next beat to write address 0.
  - `o_smIsBooted` stays 0 until BOOT_WORDS fresh beats have completed.
